// File: rtl/mult_sched.sv
// Round-robin front end for a shared multi-cycle multiplier. It arbitrates four
// requesters, launches one multiply at a time, and returns the product or a timeout abort.
module mult_sched #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] a_in,
  input  logic [4*DW-1:0] b_in,
  output logic [3:0]      gnt,
  output logic            busy,
  output logic            mul_start,
  output logic [DW-1:0]   mul_a,
  output logic [DW-1:0]   mul_b,
  input  logic            mul_done,
  input  logic [2*DW-1:0] mul_result,
  output logic            rsp_valid,
  output logic [1:0]      rsp_id,
  output logic [2*DW-1:0] rsp_data,
  output logic            rsp_err,
  input  logic            rsp_ready
);

  localparam int NREQ = 4;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_e;

  state_e                      state_q;
  logic                        busy_q, mul_start_q, rsp_valid_q, rsp_err_q;
  logic [DW-1:0]               op_a_q, op_b_q;
  logic [2*DW-1:0]             rsp_data_q;
  logic [1:0]                  rsp_id_q, last_id_q;
  logic [7:0]                  timer_q;

  logic [NREQ-1:0][DW-1:0]     a_sl, b_sl;
  logic                        win_vld;
  logic [1:0]                  win_id;

  assign a_sl = a_in;
  assign b_sl = b_in;

  // Search starts one past the last served requester; the 2-bit add wraps mod 4.
  always_comb begin
    logic [1:0] idx;
    win_vld = 1'b0;
    win_id  = 2'd0;
    idx     = 2'd0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = last_id_q + 2'(k);
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  assign gnt = (state_q == S_IDLE && win_vld) ? (4'b0001 << win_id) : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      mul_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 2'd0;
      timer_q     <= '0;
      last_id_q   <= 2'd3;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            state_q     <= S_LAUNCH;
            busy_q      <= 1'b1;
            mul_start_q <= 1'b1;
            op_a_q      <= a_sl[win_id];
            op_b_q      <= b_sl[win_id];
            rsp_id_q    <= win_id;
          end
        end
        S_LAUNCH: begin
          state_q     <= S_WAIT;
          mul_start_q <= 1'b0;
          timer_q     <= '0;
        end
        S_WAIT: begin
          // A completion on the last allowed cycle still counts as success.
          if (mul_done) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= mul_result;
            rsp_err_q   <= 1'b0;
          end else if (timer_q == TMO_LAST) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            last_id_q   <= rsp_id_q;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          mul_start_q <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign mul_start = mul_start_q;
  assign mul_a     = op_a_q;
  assign mul_b     = op_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mult_sched.sv
// Directed bench for mult_sched: the bench plays the multiplier and checks arbitration,
// launch, completion, timeout, backpressure and reset behaviour against constants.
module tb_mult_sched;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic            clk, rst;
  logic [3:0]      req;
  logic [4*DW-1:0] a_in, b_in;
  logic [3:0]      gnt;
  logic            busy, mul_start;
  logic [DW-1:0]   mul_a, mul_b;
  logic            mul_done;
  logic [2*DW-1:0] mul_result;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [2*DW-1:0] rsp_data;
  logic            rsp_err, rsp_ready;

  int n_chk  = 0;
  int n_pass = 0;

  mult_sched #(.DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .busy(busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction; mul_done is raised on WAIT cycle dly (1-based).
  task automatic txn(input logic [3:0] r, input int id, input int ea, input int eb,
                     input int ep, input int dly, input bit hold);
    req = r;
    #1 chk("gnt", gnt, 32'(1 << id));
    chk("idle_busy", busy, 0);
    tick;
    if (!hold) req = 4'b0000;
    #1 chk("launch_start", mul_start, 1);
    chk("launch_gnt", gnt, 0);
    chk("launch_busy", busy, 1);
    chk("launch_a", mul_a, ea);
    chk("launch_b", mul_b, eb);
    tick;
    #1 chk("wait_start", mul_start, 0);
    chk("wait_a", mul_a, ea);
    chk("wait_b", mul_b, eb);
    repeat (dly - 1) tick;
    mul_done = 1'b1;
    mul_result = 16'(ep);
    tick;
    mul_done = 1'b0;
    mul_result = 16'hdead;
    #1 chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, id);
    chk("rsp_data", rsp_data, ep);
    chk("rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    #1 chk("done_busy", busy, 0);
    chk("done_valid", rsp_valid, 0);
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; mul_done = 1'b0; mul_result = '0; rsp_ready = 1'b0;
    a_in = {8'd200, 8'd7, 8'd4, 8'd3};
    b_in = {8'd250, 8'd9, 8'd6, 8'd5};
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", mul_start, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_a", mul_a, 0);
    chk("rst_b", mul_b, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_id", rsp_id, 0);
    tick;
    rst = 1'b0;

    // basic 3*5
    txn(4'b0001, 0, 3, 5, 15, 1, 0);

    // fresh reset, then all requesting: 0,1,2,3,0
    rst = 1'b1; tick; rst = 1'b0;
    txn(4'b1111, 0, 3, 5, 15, 1, 1);
    txn(4'b1111, 1, 4, 6, 24, 2, 1);
    txn(4'b1111, 2, 7, 9, 63, 3, 1);
    txn(4'b1111, 3, 200, 250, 50000, 1, 1);
    txn(4'b1111, 0, 3, 5, 15, 1, 0);

    // wrap-around with sparse requests
    txn(4'b1001, 3, 200, 250, 50000, 1, 0);
    txn(4'b1001, 0, 3, 5, 15, 2, 0);

    // timeout abort, then response backpressure
    req = 4'b0100;
    #1 chk("tmo_gnt", gnt, 4'b0100);
    tick; req = 4'b0000;
    tick;
    repeat (TMO - 1) tick;
    chk("tmo_early_valid", rsp_valid, 0);
    chk("tmo_a_stable", mul_a, 7);
    tick;
    chk("tmo_valid", rsp_valid, 1);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_data", rsp_data, 0);
    chk("tmo_id", rsp_id, 2);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("stall_valid", rsp_valid, 1);
      chk("stall_err", rsp_err, 1);
      chk("stall_data", rsp_data, 0);
      chk("stall_id", rsp_id, 2);
      chk("stall_gnt", gnt, 0);
      chk("stall_busy", busy, 1);
    end
    req = 4'b0000;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("stall_exit_busy", busy, 0);
    chk("stall_exit_valid", rsp_valid, 0);

    // done on the last allowed WAIT cycle beats the timeout
    txn(4'b0010, 1, 4, 6, 24, TMO, 0);

    // reset during WAIT; late done must be ignored; priority back to 0
    req = 4'b0001;
    #1 chk("rw_gnt", gnt, 4'b0001);
    tick; req = 4'b0000;
    tick;
    tick;
    rst = 1'b1;
    #1 chk("rw_busy", busy, 0);
    chk("rw_start", mul_start, 0);
    chk("rw_valid", rsp_valid, 0);
    chk("rw_a", mul_a, 0);
    chk("rw_b", mul_b, 0);
    chk("rw_data", rsp_data, 0);
    chk("rw_id", rsp_id, 0);
    chk("rw_err", rsp_err, 0);
    tick;
    rst = 1'b0;
    mul_done = 1'b1;
    mul_result = 16'd1234;
    tick;
    mul_done = 1'b0;
    chk("late_done_valid", rsp_valid, 0);
    chk("late_done_busy", busy, 0);
    chk("late_done_data", rsp_data, 0);
    req = 4'b1111;
    #1 chk("post_rst_gnt", gnt, 4'b0001);
    req = 4'b0000;
    tick;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
